// File: rtl/bus_pkg.sv
// Shared constants, types and helpers for the push-bus receiver.
package bus_pkg;

    localparam int BUS_WIDTH = 4;
    localparam int BUS_DEPTH = 8;
    localparam int BUS_SLACK = 4;

    typedef logic [BUS_WIDTH-1:0] bus_word_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/bus_rx_mem.sv
// Receiver FIFO storage: one write port, asynchronous read port.
module bus_rx_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage deliberately has no reset; occupancy lives in the top.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_pipe_receiver.sv
// Fixed-latency push-bus receiver with registered credit and FIFO.
// Optional level/hwm ports when BUS_RX_LEVEL_EN is defined.
module bus_pipe_receiver
    import bus_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int DEPTH = BUS_DEPTH,
    parameter int SLACK = BUS_SLACK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
    output logic                  ovf,
    input  logic                  ovf_clr
`ifdef BUS_RX_LEVEL_EN
    ,
    output logic [clog2(DEPTH):0] level,
    output logic [clog2(DEPTH):0] hwm
`endif
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CREDIT_C = CW'(DEPTH - SLACK);

    if (SLACK >= DEPTH) begin : g_slack_chk
        $fatal(1, "bus_pipe_receiver: SLACK must be below DEPTH");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $fatal(1, "bus_pipe_receiver: DEPTH must be a power of two >= 2");
    end

    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] rdata;
    logic             full;
    logic             push;
    logic             pop;
    logic             overflow;

    assign full      = (count == DEPTH_C);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // in_ready is not consulted: in-flight words must always land.
    assign push      = in_valid & (~full | pop);
    assign overflow  = in_valid & full & ~pop;

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            in_ready <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            count    <= count_next;
            in_ready <= (count_next <= CREDIT_C);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (overflow)     ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    bus_rx_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr),
        .wdata(in_data),
        .raddr(rd_ptr),
        .rdata(rdata)
    );

    // Gate with out_valid so out_data reads zero in and after reset.
    assign out_data = out_valid ? rdata : '0;

`ifdef BUS_RX_LEVEL_EN
    assign level = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      hwm <= '0;
        else if (ovf_clr)             hwm <= '0;
        else if (count_next > hwm)    hwm <= count_next;
    end
`endif

endmodule

// File: tb/tb_bus_pipe_receiver.sv
// Scoreboard bench for bus_pipe_receiver (WIDTH=4, DEPTH=8, SLACK=4).
module tb_bus_pipe_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;
    logic       ovf;
    logic       ovf_clr;
`ifdef BUS_RX_LEVEL_EN
    logic [3:0] level;
    logic [3:0] hwm;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    bus_pipe_receiver #(.WIDTH(4), .DEPTH(8), .SLACK(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
`ifdef BUS_RX_LEVEL_EN
        ,
        .level    (level),
        .hwm      (hwm)
`endif
    );

    // Monitor: every accepted head word must match the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected: got %h, expected none", out_data);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_bad++;
                    $display("FAIL pop_data: got %h, expected %h", out_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus; returns #1 after the consuming edge.
    task automatic cyc(input logic v, input logic [3:0] d, input logic ordy,
                       input logic clr, input logic accept);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        ovf_clr   = clr;
        if (v && accept) exp_q.push_back(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {3'b0, in_ready}, 4'h0);
        chk("rst_out_valid", {3'b0, out_valid}, 4'h0);
        chk("rst_ovf", {3'b0, ovf}, 4'h0);
        chk("rst_out_data", out_data, 4'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready_pre", {3'b0, in_ready}, 4'h0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_post", {3'b0, in_ready}, 4'h1);
        chk("rel_out_valid", {3'b0, out_valid}, 4'h0);

        // Streaming with consumer always ready
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 4'(i), 1'b1, 1'b0, 1'b1);
            chk("stream_head", out_data, 4'(i));
            chk("stream_in_ready", {3'b0, in_ready}, 4'h1);
        end
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("stream_empty", {3'b0, out_valid}, 4'h0);

        // Credit drop: consumer stalled
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 4'(i), 1'b0, 1'b0, 1'b1);
            chk("credit_in_ready", {3'b0, in_ready}, (i <= 4) ? 4'h1 : 4'h0);
        end
        for (int i = 6; i <= 8; i++) begin
            cyc(1'b1, 4'(i), 1'b0, 1'b0, 1'b1);
            chk("slack_in_ready", {3'b0, in_ready}, 4'h0);
        end
        chk("full_ovf", {3'b0, ovf}, 4'h0);
        chk("full_head", out_data, 4'h1);

        // Overflow, then clear
        cyc(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", {3'b0, ovf}, 4'h1);
        chk("ovf_head", out_data, 4'h1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("ovf_clr", {3'b0, ovf}, 4'h0);
        // Overflow and clear together: set wins
        cyc(1'b1, 4'hB, 1'b0, 1'b1, 1'b0);
        chk("ovf_set_wins", {3'b0, ovf}, 4'h1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("ovf_clr2", {3'b0, ovf}, 4'h0);

        // Full with simultaneous push and pop
        cyc(1'b1, 4'hA, 1'b1, 1'b0, 1'b1);
        chk("fullpp_ovf", {3'b0, ovf}, 4'h0);
        chk("fullpp_in_ready", {3'b0, in_ready}, 4'h0);
        chk("fullpp_head", out_data, 4'h2);
        for (int i = 0; i < 8; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("drain_empty", {3'b0, out_valid}, 4'h0);
        chk("drain_in_ready", {3'b0, in_ready}, 4'h1);
        chk("drain_sb", 4'(exp_q.size()), 4'h0);

        // Mid-stream reset
        for (int i = 1; i <= 6; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'hF, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'hE, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'hD, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_ovf", {3'b0, ovf}, 4'h1);
        for (int i = 0; i < 2; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(4'h0);
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("arst_out_valid", {3'b0, out_valid}, 4'h0);
        chk("arst_in_ready", {3'b0, in_ready}, 4'h0);
        chk("arst_ovf", {3'b0, ovf}, 4'h0);
        chk("arst_out_data", out_data, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel2_in_ready", {3'b0, in_ready}, 4'h1);
        cyc(1'b1, 4'h3, 1'b1, 1'b0, 1'b1);
        chk("post_rst_head", out_data, 4'h3);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_empty", {3'b0, out_valid}, 4'h0);
        chk("end_sb", 4'(exp_q.size()), 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
